// File: rtl/alu_stage_pkg.sv
// rtl/alu_stage_pkg.sv - opcodes, flag bit positions and FSM states shared by the ALU stage
package alu_stage_pkg;

   localparam int DEF_WIDTH = 16;

   localparam int FLAG_Z = 3;
   localparam int FLAG_C = 2;
   localparam int FLAG_N = 1;
   localparam int FLAG_O = 0;

   typedef enum logic [3:0] {
      OP_PASS_A = 4'h0,
      OP_PASS_B = 4'h1,
      OP_NOT_A  = 4'h2,
      OP_NOT_B  = 4'h3,
      OP_ADD    = 4'h4,
      OP_ADC    = 4'h5,
      OP_SUB    = 4'h6,
      OP_AND    = 4'h7,
      OP_OR     = 4'h8,
      OP_XOR    = 4'h9,
      OP_NAND   = 4'hA,
      OP_LSL    = 4'hB,
      OP_LSR    = 4'hC,
      OP_ASR    = 4'hD,
      OP_ROL    = 4'hE,
      OP_MUL    = 4'hF
   } alu_op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_MUL  = 2'd2
   } state_e;

endpackage

// File: rtl/alu_stage_if.sv
// rtl/alu_stage_if.sv - request/result bundle between the register file datapath and the ALU stage
interface alu_stage_if
   import alu_stage_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
);
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [3:0]       fun_sel;
   logic             wf;
   logic             start;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] alu_out;
   logic [3:0]       flags_out;

   modport master (
      output a, b, fun_sel, wf, start,
      input  busy, done, alu_out, flags_out
   );

   modport slave (
      input  a, b, fun_sel, wf, start,
      output busy, done, alu_out, flags_out
   );
endinterface

// File: rtl/alu_stage_mul.sv
// rtl/alu_stage_mul.sv - alu_mul_serial: shift-add multiplier, one partial product per edge
module alu_mul_serial #(
   parameter int WIDTH = 16
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_start,
   input  logic [WIDTH-1:0]   i_a,
   input  logic [WIDTH-1:0]   i_b,
   output logic               o_done,
   output logic [2*WIDTH-1:0] o_product
);
   localparam int CW = $clog2(WIDTH) + 1;

   logic [CW-1:0]      r_cnt;
   logic               r_run;
   logic [2*WIDTH-1:0] r_mcand;
   logic [2*WIDTH-1:0] r_prod;
   logic [WIDTH-1:0]   r_mplier;
   logic [2*WIDTH-1:0] w_prod_nxt;

   // o_done/o_product describe the iteration in flight so the caller can register them on its final edge
   assign w_prod_nxt = r_prod + (r_mplier[0] ? r_mcand : '0);
   assign o_product  = w_prod_nxt;
   assign o_done     = r_run && (r_cnt == CW'(WIDTH - 1));

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt    <= '0;
         r_run    <= 1'b0;
         r_mcand  <= '0;
         r_prod   <= '0;
         r_mplier <= '0;
      end else if (i_start) begin
         r_cnt    <= '0;
         r_run    <= 1'b1;
         r_mcand  <= {{WIDTH{1'b0}}, i_a};
         r_prod   <= '0;
         r_mplier <= i_b;
      end else if (r_run) begin
         r_prod   <= w_prod_nxt;
         r_mcand  <= r_mcand << 1;
         r_mplier <= r_mplier >> 1;
         r_cnt    <= r_cnt + 1'b1;
         if (o_done) r_run <= 1'b0;
      end
   end
endmodule

// File: rtl/alu_stage.sv
// rtl/alu_stage.sv - registered ALU stage with Z/C/N/O flags
// ALU_STAGE_MUL_EN enables the serial multiplier for opcode F; otherwise F is a NOP.
module alu_stage
   import alu_stage_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   alu_stage_if.slave  io_bus
);
`ifdef ALU_STAGE_MUL_EN
   localparam bit MUL_ENABLED = 1'b1;
`else
   localparam bit MUL_ENABLED = 1'b0;
`endif

   state_e             r_state;
   state_e             w_state_nxt;
   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_b;
   alu_op_e            r_op;
   logic               r_wf;
   logic [WIDTH-1:0]   r_alu_out;
   logic [3:0]         r_flags;
   logic               r_done;

   logic               w_accept;
   logic               w_finish;
   logic               w_nop;
   logic [WIDTH-1:0]   w_res;
   logic [WIDTH:0]     w_sum;
   logic               w_c;
   logic               w_o;
   logic [3:0]         w_flags_nxt;
   logic               w_mul_done;
   logic [2*WIDTH-1:0] w_mul_prod;

`ifdef ALU_STAGE_MUL_EN
   alu_mul_serial #(.WIDTH(WIDTH)) u_mul (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_start   (w_accept && (w_state_nxt == S_MUL)),
      .i_a       (io_bus.a),
      .i_b       (io_bus.b),
      .o_done    (w_mul_done),
      .o_product (w_mul_prod)
   );
`else
   assign w_mul_done = 1'b0;
   assign w_mul_prod = '0;
`endif

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= S_IDLE;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_finish    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (io_bus.start) begin
               w_accept    = 1'b1;
               w_state_nxt = (MUL_ENABLED && (alu_op_e'(io_bus.fun_sel) == OP_MUL)) ? S_MUL : S_EXEC;
            end
         end
         S_EXEC: begin
            w_finish    = 1'b1;
            w_state_nxt = S_IDLE;
         end
         S_MUL: begin
            if (w_mul_done) begin
               w_finish    = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // C and O default to their registered values so logic/pass ops leave them untouched
   always_comb begin
      w_res = r_alu_out;
      w_sum = '0;
      w_c   = r_flags[FLAG_C];
      w_o   = r_flags[FLAG_O];
      w_nop = 1'b0;
      case (r_op)
         OP_PASS_A: w_res = r_a;
         OP_PASS_B: w_res = r_b;
         OP_NOT_A:  w_res = ~r_a;
         OP_NOT_B:  w_res = ~r_b;
         OP_ADD: begin
            w_sum = {1'b0, r_a} + {1'b0, r_b};
            w_res = w_sum[WIDTH-1:0];
            w_c   = w_sum[WIDTH];
            w_o   = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_res[WIDTH-1] != r_a[WIDTH-1]);
         end
         OP_ADC: begin
            w_sum = {1'b0, r_a} + {1'b0, r_b} + {{WIDTH{1'b0}}, r_flags[FLAG_C]};
            w_res = w_sum[WIDTH-1:0];
            w_c   = w_sum[WIDTH];
            w_o   = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_res[WIDTH-1] != r_a[WIDTH-1]);
         end
         OP_SUB: begin
            w_sum = {1'b0, r_a} + {1'b0, ~r_b} + {{WIDTH{1'b0}}, 1'b1};
            w_res = w_sum[WIDTH-1:0];
            w_c   = w_sum[WIDTH];
            w_o   = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_res[WIDTH-1] != r_a[WIDTH-1]);
         end
         OP_AND:  w_res = r_a & r_b;
         OP_OR:   w_res = r_a | r_b;
         OP_XOR:  w_res = r_a ^ r_b;
         OP_NAND: w_res = ~(r_a & r_b);
         OP_LSL: begin
            w_res = r_a << 1;
            w_c   = r_a[WIDTH-1];
         end
         OP_LSR: begin
            w_res = r_a >> 1;
            w_c   = r_a[0];
         end
         OP_ASR: begin
            w_res = {r_a[WIDTH-1], r_a[WIDTH-1:1]};
            w_c   = r_a[0];
         end
         OP_ROL: begin
            w_res = {r_a[WIDTH-2:0], r_flags[FLAG_C]};
            w_c   = r_a[WIDTH-1];
         end
         OP_MUL: begin
            if (r_state == S_MUL) begin
               w_res = w_mul_prod[WIDTH-1:0];
               w_c   = |w_mul_prod[2*WIDTH-1:WIDTH];
            end else begin
               w_nop = 1'b1;
            end
         end
         default: w_nop = 1'b1;
      endcase
   end

   always_comb begin
      w_flags_nxt         = 4'b0000;
      w_flags_nxt[FLAG_Z] = (w_res == '0);
      w_flags_nxt[FLAG_C] = w_c;
      w_flags_nxt[FLAG_N] = w_res[WIDTH-1];
      w_flags_nxt[FLAG_O] = w_o;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_a       <= '0;
         r_b       <= '0;
         r_op      <= OP_PASS_A;
         r_wf      <= 1'b0;
         r_alu_out <= '0;
         r_flags   <= 4'b0000;
         r_done    <= 1'b0;
      end else begin
         r_done <= w_finish;
         if (w_accept) begin
            r_a  <= io_bus.a;
            r_b  <= io_bus.b;
            r_op <= alu_op_e'(io_bus.fun_sel);
            r_wf <= io_bus.wf;
         end
         if (w_finish && !w_nop) begin
            r_alu_out <= w_res;
            if (r_wf) r_flags <= w_flags_nxt;
         end
      end
   end

   assign io_bus.busy      = (r_state != S_IDLE);
   assign io_bus.done      = r_done;
   assign io_bus.alu_out   = r_alu_out;
   assign io_bus.flags_out = r_flags;
endmodule

// File: tb/tb_alu_stage.sv
// tb/tb_alu_stage.sv - directed vector bench for alu_stage; honours ALU_STAGE_MUL_EN
module tb_alu_stage;
   import alu_stage_pkg::*;

`ifdef ALU_STAGE_MUL_EN
   localparam bit MUL_ON = 1'b1;
`else
   localparam bit MUL_ON = 1'b0;
`endif

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [3:0]  fs;
      logic        wf;
      logic [15:0] out;
      logic [3:0]  flags;
      int          edges;
   } vec_t;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;
   vec_t vecs[$];

   alu_stage_if #(.WIDTH(16)) bus ();

   alu_stage #(.WIDTH(16)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .io_bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic add_vec(input logic [15:0] a, b, input logic [3:0] fs, input logic wf,
                          input logic [15:0] out, input logic [3:0] flags, input int edges);
      vec_t v;
      v.a = a; v.b = b; v.fs = fs; v.wf = wf; v.out = out; v.flags = flags; v.edges = edges;
      vecs.push_back(v);
   endtask

   // Returns the number of edges from the accepting edge to the one that raised done
   task automatic run_op(input logic [15:0] a, b, input logic [3:0] fs, input logic wf, output int edges);
      @(negedge clk);
      bus.a = a; bus.b = b; bus.fun_sel = fs; bus.wf = wf; bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0; bus.a = ~a; bus.b = ~b;
      edges = 1;
      while (!bus.done && edges < 40) begin
         @(posedge clk); #1;
         edges++;
      end
   endtask

   initial begin
      int edges;
      logic [15:0] avals[6];
      checks = 0;
      failures = 0;
      rst_n = 1'b0;
      bus.a = '0; bus.b = '0; bus.fun_sel = '0; bus.wf = 1'b0; bus.start = 1'b0;

      // Flags column is {Z,C,N,O}; each row depends on flags left by the row before
      add_vec(16'hFFFF, 16'h0001, 4'h4, 1'b1, 16'h0000, 4'hC, 2);
      add_vec(16'h7FFF, 16'h0001, 4'h4, 1'b1, 16'h8000, 4'h3, 2);
      add_vec(16'h0000, 16'h0001, 4'h6, 1'b1, 16'hFFFF, 4'h2, 2);
      add_vec(16'hFFFF, 16'h0001, 4'h5, 1'b1, 16'h0000, 4'hC, 2);
      add_vec(16'h0001, 16'h0001, 4'h5, 1'b1, 16'h0003, 4'h0, 2);
      add_vec(16'h0005, 16'h0003, 4'h6, 1'b1, 16'h0002, 4'h4, 2);
      add_vec(16'hF0F0, 16'hFF00, 4'h7, 1'b1, 16'hF000, 4'h6, 2);
      add_vec(16'h00F0, 16'h0F00, 4'h8, 1'b1, 16'h0FF0, 4'h4, 2);
      add_vec(16'hAAAA, 16'hAAAA, 4'h9, 1'b1, 16'h0000, 4'hC, 2);
      add_vec(16'hFFFF, 16'hFFFF, 4'hA, 1'b1, 16'h0000, 4'hC, 2);
      add_vec(16'h8000, 16'h1234, 4'h0, 1'b1, 16'h8000, 4'h6, 2);
      add_vec(16'h0000, 16'h1234, 4'h1, 1'b1, 16'h1234, 4'h4, 2);
      add_vec(16'h0000, 16'h1234, 4'h2, 1'b1, 16'hFFFF, 4'h6, 2);
      add_vec(16'h0000, 16'hFFFF, 4'h3, 1'b1, 16'h0000, 4'hC, 2);
      add_vec(16'h8001, 16'h0000, 4'hB, 1'b1, 16'h0002, 4'h4, 2);
      add_vec(16'h0002, 16'h0000, 4'hC, 1'b1, 16'h0001, 4'h0, 2);
      add_vec(16'h8000, 16'h0000, 4'hE, 1'b1, 16'h0000, 4'hC, 2);
      add_vec(16'h0001, 16'h0000, 4'hE, 1'b1, 16'h0003, 4'h0, 2);
      add_vec(16'h8001, 16'h0000, 4'hD, 1'b1, 16'hC000, 4'h6, 2);
      add_vec(16'h0002, 16'h0000, 4'hD, 1'b0, 16'h0001, 4'h6, 2);
      add_vec(16'hFFFF, 16'h0001, 4'h4, 1'b0, 16'h0000, 4'h6, 2);
      add_vec(16'h8000, 16'h0001, 4'h6, 1'b1, 16'h7FFF, 4'h5, 2);
      if (MUL_ON) begin
         add_vec(16'h0100, 16'h0300, 4'hF, 1'b1, 16'h0000, 4'hD, 17);
         add_vec(16'h0003, 16'h0005, 4'hF, 1'b1, 16'h000F, 4'h1, 17);
      end else begin
         add_vec(16'h0100, 16'h0300, 4'hF, 1'b1, 16'h7FFF, 4'h5, 2);
         add_vec(16'h0003, 16'h0005, 4'hF, 1'b1, 16'h7FFF, 4'h5, 2);
      end

      #2;
      chk("reset_out", {16'h0, bus.alu_out}, 32'h0);
      chk("reset_flags", {28'h0, bus.flags_out}, 32'h0);
      chk("reset_busy", {31'h0, bus.busy}, 32'h0);
      chk("reset_done", {31'h0, bus.done}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         run_op(vecs[i].a, vecs[i].b, vecs[i].fs, vecs[i].wf, edges);
         chk($sformatf("vec%0d_edges", i), edges, vecs[i].edges);
         chk($sformatf("vec%0d_out", i), {16'h0, bus.alu_out}, {16'h0, vecs[i].out});
         chk($sformatf("vec%0d_flags", i), {28'h0, bus.flags_out}, {28'h0, vecs[i].flags});
      end

      // Start held for six edges: only A seen on the accepting edges (1, 3, 5) is used
      avals[0] = 16'h1111; avals[1] = 16'h2222; avals[2] = 16'h3333;
      avals[3] = 16'h4444; avals[4] = 16'h5555; avals[5] = 16'h6666;
      @(negedge clk);
      bus.fun_sel = 4'h0; bus.wf = 1'b1; bus.b = 16'h0000; bus.start = 1'b1; bus.a = avals[0];
      for (int e = 0; e < 6; e++) begin
         @(posedge clk); #1;
         if (e < 5) bus.a = avals[e+1];
         chk($sformatf("hold_busy_e%0d", e + 1), {31'h0, bus.busy}, {31'h0, (e % 2 == 0)});
         chk($sformatf("hold_done_e%0d", e + 1), {31'h0, bus.done}, {31'h0, (e % 2 == 1)});
         if (e % 2 == 1)
            chk($sformatf("hold_out_e%0d", e + 1), {16'h0, bus.alu_out}, {16'h0, avals[e-1]});
      end
      bus.start = 1'b0;
      @(posedge clk); #1;
      chk("hold_tail_busy", {31'h0, bus.busy}, 32'h0);
      chk("hold_tail_done", {31'h0, bus.done}, 32'h0);

      // Reset in the middle of an operation: outputs clear immediately, no done afterwards
      @(negedge clk);
      bus.a = 16'h0100; bus.b = 16'h0300; bus.fun_sel = MUL_ON ? 4'hF : 4'h4; bus.wf = 1'b1; bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      if (MUL_ON) begin
         for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
         end
      end
      chk("pre_reset_busy", {31'h0, bus.busy}, 32'h1);
      rst_n = 1'b0;
      #1;
      chk("midrst_out", {16'h0, bus.alu_out}, 32'h0);
      chk("midrst_flags", {28'h0, bus.flags_out}, 32'h0);
      chk("midrst_busy", {31'h0, bus.busy}, 32'h0);
      chk("midrst_done", {31'h0, bus.done}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      edges = 0;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk); #1;
         if (bus.done || bus.busy) edges++;
      end
      chk("post_reset_quiet", edges, 0);

      run_op(16'h0ABC, 16'h0000, 4'h0, 1'b1, edges);
      chk("post_reset_edges", edges, 2);
      chk("post_reset_out", {16'h0, bus.alu_out}, 32'h0ABC);
      chk("post_reset_flags", {28'h0, bus.flags_out}, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
